// File: rtl/addr_gen_pkg.sv
// Shared select encodings and offset field widths for the effective-address pipeline.
package addr_gen_pkg;

    typedef enum logic [1:0] {
        OFF11 = 2'b00,
        OFF9  = 2'b01,
        OFF6  = 2'b10,
        ZERO  = 2'b11
    } addr2_sel_t;

    typedef enum logic {
        SEL_PC  = 1'b0,
        SEL_REG = 1'b1
    } addr1_sel_t;

    localparam int OFF11_W = 11;
    localparam int OFF9_W  = 9;
    localparam int OFF6_W  = 6;

endpackage

// File: rtl/addr_gen_pipe_stage.sv
// One valid/ready register slice. A beat transfers on in_valid && in_ready, and in_ready is
// high when the slice is empty or its own beat leaves this cycle (out_valid && out_ready).
module pipe_stage
    import addr_gen_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Flush only drops the valid bit; the payload register keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/addr_gen_pipe.sv
// Two-stage effective-address generator: stage 1 latches base and sign-extended offset,
// stage 2 latches their wrap-around sum.
module addr_gen_pipe
    import addr_gen_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR2_SELW = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           ir,
    input  logic [WIDTH-1:0]      pc,
    input  logic [WIDTH-1:0]      base_reg,
    input  logic                  addr1_sel,
    input  logic [ADDR2_SELW-1:0] addr2_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      addr_out
);

    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   offset;
    logic [WIDTH-1:0]   sum;
    logic [2*WIDTH-1:0] s1_data;
    logic               s1_valid;
    logic               s1_ready;
    logic               s2_ready;
    logic               unused_ir;

    assign unused_ir = ^ir[15:OFF11_W];

    assign base = (addr1_sel_t'(addr1_sel) == SEL_REG) ? base_reg : pc;

    always_comb begin
        offset = '0;
        case (addr2_sel_t'(addr2_sel[1:0]))
            OFF11: offset = {{(WIDTH-OFF11_W){ir[OFF11_W-1]}}, ir[OFF11_W-1:0]};
            OFF9:  offset = {{(WIDTH-OFF9_W){ir[OFF9_W-1]}}, ir[OFF9_W-1:0]};
            OFF6:  offset = {{(WIDTH-OFF6_W){ir[OFF6_W-1]}}, ir[OFF6_W-1:0]};
            ZERO:  offset = '0;
        endcase
    end

    // The flush cycle always reports ready; the beat offered then is dropped inside the slice.
    assign in_ready = s1_ready || flush;

    pipe_stage #(.W(2*WIDTH)) u_stage1 (
        .clk       (Clk),
        .rst       (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s1_ready),
        .in_data   ({base, offset}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign sum = s1_data[2*WIDTH-1:WIDTH] + s1_data[WIDTH-1:0];

    pipe_stage #(.W(WIDTH)) u_stage2 (
        .clk       (Clk),
        .rst       (Reset),
        .flush     (flush),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (addr_out)
    );

endmodule

// File: tb/tb_addr_gen_pipe.sv
// Bench for addr_gen_pipe: queue-based reference of accepted transactions checked every cycle,
// plus directed scenarios with hand-computed addresses.
module tb_addr_gen_pipe;

    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  ir = '0;
    logic [W-1:0] pc = '0;
    logic [W-1:0] base_reg = '0;
    logic         addr1_sel = 1'b0;
    logic [1:0]   addr2_sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] addr_out;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_dut_out = 0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    always #5 Clk = ~Clk;

    addr_gen_pipe #(.WIDTH(W), .ADDR2_SELW(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .pc        (pc),
        .base_reg  (base_reg),
        .addr1_sel (addr1_sel),
        .addr2_sel (addr2_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addr_out  (addr_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Effective address from the architectural rule: base plus signed field value, mod 2^W.
    function automatic logic [W-1:0] ea(input logic [W-1:0] p, input logic [W-1:0] b,
                                        input logic s1, input logic [1:0] s2,
                                        input logic [15:0] i);
        int base_v;
        int off;
        base_v = s1 ? int'(b) : int'(p);
        case (s2)
            2'd0:    off = int'(i[10:0]) - (i[10] ? 2048 : 0);
            2'd1:    off = int'(i[8:0]) - (i[8] ? 512 : 0);
            2'd2:    off = int'(i[5:0]) - (i[5] ? 64 : 0);
            default: off = 0;
        endcase
        return W'(base_v + off);
    endfunction

    // Reference update: the oldest entry is on the output once two edges have passed since
    // its handshake cycle; with two entries in flight the input is ready only if the output drains.
    always @(posedge Clk) begin
        logic m_ready;
        logic m_ov;
        if (Reset || flush) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            m_ready = (exp_q.size() < 2) || out_ready;
            m_ov = 1'b0;
            if (exp_q.size() > 0) m_ov = (cyc - acc_q[0]) >= 2;
            if (m_ov && out_ready) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (in_valid && m_ready) begin
                exp_q.push_back(ea(pc, base_reg, addr1_sel, addr2_sel, ir));
                acc_q.push_back(cyc);
            end
        end
        cyc++;
    end

    always @(negedge Clk) begin
        logic m_ov;
        if (!Reset) begin
            m_ov = 1'b0;
            if (exp_q.size() > 0) m_ov = (cyc - acc_q[0]) >= 2;
            chk("in_ready", in_ready, flush || (exp_q.size() < 2) || out_ready);
            chk("out_valid", out_valid, m_ov);
            if (m_ov) chk("addr_out", addr_out, exp_q[0]);
            if (out_valid && out_ready) n_dut_out++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic [W-1:0] p, input logic [W-1:0] b, input logic s1,
                          input logic [1:0] s2, input logic [15:0] i);
        pc = p;
        base_reg = b;
        addr1_sel = s1;
        addr2_sel = s2;
        ir = i;
        in_valid = 1'b1;
    endtask

    // Hold the current operand set until it is accepted, bounded by a cycle budget.
    task automatic send_wait();
        logic acc;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: no handshake within 40 cycles (cycle %0d)", cyc);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic directed(input string name, input logic [W-1:0] p, input logic [W-1:0] b,
                            input logic s1, input logic [1:0] s2, input logic [15:0] i,
                            input logic [W-1:0] lit);
        drain();
        chk({name, "_model"}, ea(p, b, s1, s2, i), lit);
        set_in(p, b, s1, s2, i);
        send_wait();
        @(negedge Clk);
        chk({name, "_lat1_valid"}, out_valid, 1'b0);
        tick();
        @(negedge Clk);
        chk({name, "_lat2_valid"}, out_valid, 1'b1);
        chk({name, "_addr"}, addr_out, lit);
        tick();
    endtask

    initial begin
        int o0;
        Reset = 1'b1;
        repeat (2) tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_addr_out", addr_out, '0);
        chk("reset_in_ready", in_ready, 1'b1);
        Reset = 1'b0;

        directed("pc_off9", 16'h3000, 16'h0000, 1'b0, 2'b01, 16'h01FF, 16'h2FFF);
        directed("reg_off6", 16'h0000, 16'h4000, 1'b1, 2'b10, 16'h0020, 16'h3FE0);
        directed("wrap_off11", 16'hFFFF, 16'h0000, 1'b0, 2'b00, 16'h0001, 16'h0000);
        directed("zero_off", 16'hFFFF, 16'h0000, 1'b0, 2'b11, 16'h0001, 16'hFFFF);
        directed("neg_off11", 16'h1000, 16'h0000, 1'b0, 2'b00, 16'hF400, 16'h0C00);

        // Backpressure: two accepted, third stalls while the held result stays put.
        drain();
        out_ready = 1'b0;
        o0 = n_dut_out;
        set_in(16'h0100, 16'h0, 1'b0, 2'b11, 16'h0);
        send_wait();
        set_in(16'h0200, 16'h0, 1'b0, 2'b11, 16'h0);
        send_wait();
        set_in(16'h0300, 16'h0, 1'b0, 2'b11, 16'h0);
        repeat (3) begin
            @(negedge Clk);
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", addr_out, 16'h0100);
            tick();
        end
        out_ready = 1'b1;
        send_wait();
        set_in(16'h0400, 16'h0, 1'b0, 2'b11, 16'h0);
        send_wait();
        repeat (4) tick();
        chk("bp_delivered", n_dut_out - o0, 4);

        // Flush with two in flight and a third offered in the flush cycle.
        drain();
        out_ready = 1'b0;
        set_in(16'h0500, 16'h0, 1'b0, 2'b11, 16'h0);
        send_wait();
        set_in(16'h0600, 16'h0, 1'b0, 2'b11, 16'h0);
        send_wait();
        set_in(16'h0700, 16'h0, 1'b0, 2'b11, 16'h0);
        flush = 1'b1;
        @(negedge Clk);
        chk("flush_in_ready", in_ready, 1'b1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        o0 = n_dut_out;
        @(negedge Clk);
        chk("flush_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("flush_nothing_out", n_dut_out - o0, 0);

        // Asynchronous reset between edges with a result on the output.
        drain();
        out_ready = 1'b0;
        set_in(16'h0800, 16'h0, 1'b0, 2'b11, 16'h0);
        send_wait();
        tick();
        @(negedge Clk);
        chk("pre_reset_valid", out_valid, 1'b1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_addr_out", addr_out, '0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        out_ready = 1'b1;
        set_in(16'h1234, 16'h0, 1'b0, 2'b01, 16'h0002);
        @(negedge Clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge Clk);
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_addr", addr_out, 16'h1236);
        tick();

        // Random traffic: mostly-ready, then heavy backpressure, with rare flushes.
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                out_ready = (ph == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                flush = ($urandom_range(0, 63) == 0);
                pc = W'($urandom);
                base_reg = W'($urandom);
                addr1_sel = 1'($urandom_range(0, 1));
                addr2_sel = 2'($urandom_range(0, 3));
                ir = 16'($urandom);
                tick();
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
